clause_stream_loader: RTL and testbench
=======================================

# clause_stream_loader

Sequential front-end that walks a packed clause-database image in an external word memory and streams it into the lookup top level. For each engine it replays clause nodes, then dummy pointers, then pulses the engine-change strobe; after the last engine it streams the initial unit literals with a done strobe. It drives the `node_in`/`dummy_ptr`/`change_eng`/`mem2uca*` inputs of the lookup top level, replacing testbench-driven loading.

## Interface
Parameters:
- `ENG_CNT`, default `` `NUM_ENGINE ``: number of engine sections in the image.
- `DATA_W`, default 32: memory word width; must be ≥ widths of `node_t`, `dummy_entry_t`, `lit_t`.
- `ADDR_W`, default 16: memory address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin load; sampled only in IDLE/DONE.
- `base_addr`, in, ADDR_W: image start address, latched on accepted `start`.
- `mem_req`, out, 1: read request, one-cycle pulse.
- `mem_addr`, out, ADDR_W: read address, valid with `mem_req`.
- `mem_rvalid`, in, 1: read data valid; arbitrary latency ≥1, one outstanding.
- `mem_rdata`, in, DATA_W: read data.
- `node_out`, out, node_t: clause node (low bits of word).
- `node_valid`, out, 1: one-cycle strobe.
- `ptr_out`, out, dummy_entry_t: dummy pointer.
- `ptr_valid`, out, 1: one-cycle strobe.
- `change_eng`, out, 1: one-cycle strobe, advance engine.
- `uc_lit`, out, lit_t: initial unit literal.
- `uc_valid`, out, 1: one-cycle strobe.
- `uc_done`, out, 1: one-cycle strobe after last literal.
- `busy`, out, 1: high from accepted `start` to entry into DONE.
- `done`, out, 1: level, high in DONE.
- `err`, out, 1: checksum mismatch (see Configuration); 0 when macro absent.

## Operation
- Image layout from `base_addr`, per engine e=0..ENG_CNT-1: word C_e (clause count), word P_e (pointer count), C_e node words, P_e pointer words. Then word U (unit count), U literal words, then (only with checksum) one checksum word.
- Counts use low ADDR_W bits of the word; addresses increment modulo 2^ADDR_W (wrap is legal, not an error).
- FSM states: IDLE, RD_C, RD_P, NODE, PTR, CHG, RD_U, UC, FIN, (CSUM), DONE. Each RD/NODE/PTR/UC state issues one `mem_req` and waits for `mem_rvalid`.
- IDLE/DONE + `start` → RD_C (engine idx 0). `start` in any other state is ignored.
- RD_C → RD_P. RD_P → NODE if C_e>0, else PTR if P_e>0, else CHG.
- NODE: emit word as node; after C_e-th → PTR (or CHG if P_e=0).
- PTR: emit; after P_e-th → CHG.
- CHG: pulse `change_eng` only if e<ENG_CNT-1, then e++ → RD_C; if e=ENG_CNT-1 no pulse → RD_U.
- RD_U → UC if U>0 else FIN. UC: emit literal; after U-th → FIN.
- FIN: pulse `uc_done` → CSUM (macro) or DONE.
- No backpressure from downstream; every word is forwarded.

## Timing
- Reset: all outputs 0, state IDLE, counters and engine index 0, `mem_addr` 0.
- `mem_req` asserts the cycle after entering a read state, or the cycle after the previous `mem_rvalid`; deasserts next cycle.
- Output strobes are registered: asserted exactly the cycle after the matching `mem_rvalid`, data stable that cycle.
- CHG and FIN each occupy exactly one cycle.
- `mem_rvalid` without outstanding request: ignored.
- `rst_n` low mid-load: immediate abort to reset state; outstanding response after release is ignored (IDLE).
- `busy` and `done` never high together.

## Configuration
- `LOADER_CHECKSUM_EN` defined: XOR of every image word read (counts, nodes, pointers, U, literals) is accumulated; CSUM reads one extra word; `err` set in DONE if it differs from accumulator, cleared on next accepted `start`.
- Undefined: no CSUM state, no extra read, `err` tied 0.

## Test plan
- ENG_CNT=2, image {C=2,P=1,n0,n1,p0 | C=1,P=0,n2 | U=1,l0}, latency 1 → node strobes n0,n1, ptr p0, one `change_eng`, node n2, `uc_lit`=l0, `uc_done`, `done`=1; exactly one `change_eng`.
- All counts zero, ENG_CNT=4 → 3 `change_eng` pulses, no data strobes, `uc_done` once, total 9 `mem_req`.
- Random memory latency 1..5 → identical strobe sequence; never two requests outstanding.
- `base_addr`=0xFFFE, 6-word image → addresses 0xFFFE,0xFFFF,0x0000.. wrap, output correct.
- Assert `rst_n` low during NODE → all outputs 0 next cycle; new `start` reloads full image cleanly; `start` during busy ignored.
- With `LOADER_CHECKSUM_EN`: correct XOR word → `err`=0; flipped bit → `err`=1 in DONE, cleared on restart.

Source files
------------

// File: rtl/clause_stream_loader.sv
// Walks a packed clause-database image in word memory and replays it as node/pointer/unit strobes.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum word after the unit literals).

`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

module clause_stream_loader #(
    parameter int unsigned ENG_CNT = `NUM_ENGINE,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    // Widths of node_t, dummy_entry_t and lit_t of the lookup top level.
    parameter int unsigned NODE_W  = 24,
    parameter int unsigned PTR_W   = 16,
    parameter int unsigned LIT_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [NODE_W-1:0] node_out,
    output logic              node_valid,
    output logic [PTR_W-1:0]  ptr_out,
    output logic              ptr_valid,
    output logic              change_eng,
    output logic [LIT_W-1:0]  uc_lit,
    output logic              uc_valid,
    output logic              uc_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned EngW = (ENG_CNT > 1) ? $clog2(ENG_CNT) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdC,
        StRdP,
        StNode,
        StPtr,
        StChg,
        StRdU,
        StUc,
        StFin,
`ifdef LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_c_q;   // node count, reused for unit literals
    logic [ADDR_W-1:0] cnt_p_q;
    logic [EngW-1:0]   eng_q;
    logic              outst_q;
    logic              mem_req_q, mem_req_d;
    logic              node_valid_q, node_valid_d;
    logic              ptr_valid_q, ptr_valid_d;
    logic              uc_valid_q, uc_valid_d;
    logic              change_eng_q, change_eng_d;
    logic              uc_done_q, uc_done_d;
    logic [NODE_W-1:0] node_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [LIT_W-1:0]  lit_q;

    logic              ack;
    logic              start_acc;
    logic              last_eng;
    logic [ADDR_W-1:0] rd_cnt;
    logic              unused_rdata;

    // Responses only count while a request is outstanding; strays are dropped.
    assign ack          = outst_q & mem_rvalid;
    assign start_acc    = start & ((state_q == StIdle) | (state_q == StDone));
    assign last_eng     = (eng_q == EngW'(ENG_CNT - 1));
    assign rd_cnt       = mem_rdata[ADDR_W-1:0];
    assign unused_rdata = ^mem_rdata;

    function automatic logic is_read(state_e s);
        case (s)
            StRdC, StRdP, StNode, StPtr, StRdU, StUc: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            StCsum: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StRdC;
            StRdC: if (ack) state_d = StRdP;
            StRdP: begin
                if (ack) begin
                    if (cnt_c_q != '0)      state_d = StNode;
                    else if (rd_cnt != '0)  state_d = StPtr;
                    else                    state_d = StChg;
                end
            end
            StNode: begin
                if (ack && (cnt_c_q == ADDR_W'(1))) begin
                    state_d = (cnt_p_q != '0) ? StPtr : StChg;
                end
            end
            StPtr: if (ack && (cnt_p_q == ADDR_W'(1))) state_d = StChg;
            StChg: state_d = last_eng ? StRdU : StRdC;
            StRdU: if (ack) state_d = (rd_cnt != '0) ? StUc : StFin;
            StUc:  if (ack && (cnt_c_q == ADDR_W'(1))) state_d = StFin;
`ifdef LOADER_CHECKSUM_EN
            StFin:  state_d = StCsum;
            StCsum: if (ack) state_d = StDone;
`else
            StFin:  state_d = StDone;
`endif
            default: state_d = StIdle;
        endcase
    end

    // A fresh request follows every entry into a read state and every accepted word.
    always_comb begin
        mem_req_d    = is_read(state_d) && ((state_d != state_q) || ack);
        node_valid_d = ack && (state_q == StNode);
        ptr_valid_d  = ack && (state_q == StPtr);
        uc_valid_d   = ack && (state_q == StUc);
        change_eng_d = (state_q == StChg) && !last_eng;
        uc_done_d    = (state_q == StFin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            cnt_c_q      <= '0;
            cnt_p_q      <= '0;
            eng_q        <= '0;
            outst_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            node_valid_q <= 1'b0;
            ptr_valid_q  <= 1'b0;
            uc_valid_q   <= 1'b0;
            change_eng_q <= 1'b0;
            uc_done_q    <= 1'b0;
            node_q       <= '0;
            ptr_q        <= '0;
            lit_q        <= '0;
        end else begin
            mem_req_q    <= mem_req_d;
            outst_q      <= (outst_q & ~mem_rvalid) | mem_req_q;
            node_valid_q <= node_valid_d;
            ptr_valid_q  <= ptr_valid_d;
            uc_valid_q   <= uc_valid_d;
            change_eng_q <= change_eng_d;
            uc_done_q    <= uc_done_d;
            if (node_valid_d) node_q <= mem_rdata[NODE_W-1:0];
            if (ptr_valid_d)  ptr_q  <= mem_rdata[PTR_W-1:0];
            if (uc_valid_d)   lit_q  <= mem_rdata[LIT_W-1:0];

            if (start_acc) begin
                addr_q  <= base_addr;
                cnt_c_q <= '0;
                cnt_p_q <= '0;
                eng_q   <= '0;
            end else begin
                if (ack) addr_q <= addr_q + ADDR_W'(1);
                if (state_q == StChg && !last_eng) eng_q <= eng_q + EngW'(1);
                if (ack) begin
                    case (state_q)
                        StRdC, StRdU: cnt_c_q <= rd_cnt;
                        StRdP:        cnt_p_q <= rd_cnt;
                        StNode, StUc: cnt_c_q <= cnt_c_q - ADDR_W'(1);
                        StPtr:        cnt_p_q <= cnt_p_q - ADDR_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
    logic              err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if (start_acc) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if (ack) begin
            if (state_q == StCsum) err_q <= (mem_rdata != acc_q);
            else                   acc_q <= acc_q ^ mem_rdata;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_req    = mem_req_q;
    assign mem_addr   = addr_q;
    assign node_out   = node_q;
    assign node_valid = node_valid_q;
    assign ptr_out    = ptr_q;
    assign ptr_valid  = ptr_valid_q;
    assign change_eng = change_eng_q;
    assign uc_lit     = lit_q;
    assign uc_valid   = uc_valid_q;
    assign uc_done    = uc_done_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_clause_stream_loader.sv
// Scoreboard bench for clause_stream_loader: directed images, a latency-randomised memory
// responder, and a negedge monitor that pops expected strobes.
`timescale 1ns/1ps

module tb_clause_stream_loader;

    localparam int KNode = 0;
    localparam int KPtr  = 1;
    localparam int KChg  = 2;
    localparam int KUc   = 3;
    localparam int KDone = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [23:0] node_out;
    logic        node_valid;
    logic [15:0] ptr_out;
    logic        ptr_valid;
    logic        change_eng;
    logic [11:0] uc_lit;
    logic        uc_valid;
    logic        uc_done;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    clause_stream_loader #(
        .ENG_CNT(2),
        .DATA_W (32),
        .ADDR_W (16),
        .NODE_W (24),
        .PTR_W  (16),
        .LIT_W  (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .node_out  (node_out),
        .node_valid(node_valid),
        .ptr_out   (ptr_out),
        .ptr_valid (ptr_valid),
        .change_eng(change_eng),
        .uc_lit    (uc_lit),
        .uc_valid  (uc_valid),
        .uc_done   (uc_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] img [$];
    logic [31:0] last_csum;
    int          exp_kind [$];
    logic [31:0] exp_data [$];
    int          checks = 0;
    int          errors = 0;

    int          lat_max = 1;
    bit          pending = 1'b0;
    bit          spur = 1'b0;
    int          lat_left = 0;
    logic [15:0] paddr = '0;
    int          req_cnt = 0;

    // Memory responder: one response per request after 1..lat_max cycles.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h0000_0003;
                spur       = 1'b0;
            end else if (pending) begin
                if (lat_left <= 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[paddr];
                    pending    = 1'b0;
                end else begin
                    lat_left--;
                end
            end
            if (mem_req) begin
                req_cnt++;
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL overlap: request at %h while %h outstanding, required one", mem_addr, paddr);
                end
                pending  = 1'b1;
                paddr    = mem_addr;
                lat_left = $urandom_range(lat_max, 1);
            end
        end
    end

    task automatic pop_cmp(input int kind, input logic [31:0] data, input string name);
        int          k;
        logic [31:0] d;
        checks++;
        if (exp_kind.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected strobe data %h, required none", name, data);
        end else begin
            k = exp_kind.pop_front();
            d = exp_data.pop_front();
            if (k != kind || d != data) begin
                errors++;
                $display("FAIL %s: got kind %0d data %h, required kind %0d data %h", name, kind, data, k, d);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (node_valid) pop_cmp(KNode, 32'(node_out), "node");
            if (ptr_valid)  pop_cmp(KPtr, 32'(ptr_out), "ptr");
            if (change_eng) pop_cmp(KChg, 32'h0, "change_eng");
            if (uc_valid)   pop_cmp(KUc, 32'(uc_lit), "uc_lit");
            if (uc_done)    pop_cmp(KDone, 32'h0, "uc_done");
            if (busy && done) begin
                checks++;
                errors++;
                $display("FAIL busy_done: busy=1 done=1, required not both");
            end
        end
    end

    task automatic expect_ev(input int k, input logic [31:0] d);
        exp_kind.push_back(k);
        exp_data.push_back(d);
    endtask

    task automatic load(input logic [15:0] b, input bit bad_csum);
        logic [31:0] x;
        logic [15:0] a;
        x = '0;
        for (int i = 0; i < img.size(); i++) begin
            a      = b + 16'(i);
            mem[a] = img[i];
            x      = x ^ img[i];
        end
        last_csum = bad_csum ? (x ^ 32'h0000_0100) : x;
`ifdef LOADER_CHECKSUM_EN
        a      = b + 16'(img.size());
        mem[a] = last_csum;
`endif
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic go(input logic [15:0] b);
        @(posedge clk);
        #1;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy_done_err", {29'd0, busy, done, err}, 32'b100);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_timeout"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic finish_check(input string name, input int r0, input int nreq, input logic e);
        check({name, "_leftover_events"}, 32'(exp_kind.size()), 32'd0);
        check({name, "_busy_done"}, {30'd0, busy, done}, 32'b01);
        check({name, "_err"}, {31'd0, err}, {31'd0, e});
        check({name, "_req_count"}, 32'(req_cnt - r0), 32'(nreq));
    endtask

    task automatic set_img_a();
        img = '{32'h0001_0002, 32'h0000_0001, 32'hAB12_3456, 32'h0000_0777, 32'hCAFE_0042,
                32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_5ABC};
    endtask

    task automatic expect_a();
        expect_ev(KNode, 32'h0012_3456);
        expect_ev(KNode, 32'h0000_0777);
        expect_ev(KPtr,  32'h0000_0042);
        expect_ev(KChg,  32'h0);
        expect_ev(KNode, 32'h00FF_FFFF);
        expect_ev(KUc,   32'h0000_0ABC);
        expect_ev(KDone, 32'h0);
    endtask

    initial begin
        int r0;
        int r1;
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int r1;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {mem_req, mem_addr, node_out, node_valid, ptr_out, ptr_valid, change_eng,
               uc_lit, uc_valid, uc_done, busy, done, err} == '0 ? 32'd0 : 32'd1, 32'd0);
        rst_n = 1'b1;

        // Stray response while idle must be dropped.
        spur = 1'b1;
        repeat (4) @(negedge clk);
        check("spurious_idle", {30'd0, busy, done}, 32'b00);
        check("spurious_no_req", 32'(req_cnt), 32'd0);

        // Two engines, nodes + pointer + unit literal, latency 1.
        lat_max = 1;
        set_img_a();
        load(16'h0100, 1'b0);
        expect_a();
        r0 = req_cnt;
        go(16'h0100);
        wait_done("img_a");
        finish_check("img_a", r0, 10 + CS, 1'b0);

        // All counts zero.
        img = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        load(16'h0200, 1'b0);
        expect_ev(KChg, 32'h0);
        expect_ev(KDone, 32'h0);
        r0 = req_cnt;
        go(16'h0200);
        wait_done("zeros");
        finish_check("zeros", r0, 5 + CS, 1'b0);

        // Same image as img_a under random latency 1..5.
        lat_max = 5;
        set_img_a();
        load(16'h0300, 1'b0);
        expect_a();
        r0 = req_cnt;
        go(16'h0300);
        wait_done("rand_lat");
        finish_check("rand_lat", r0, 10 + CS, 1'b0);

        // Address wrap through 0xFFFF.
        lat_max = 2;
        img = '{32'h0000_0001, 32'h0000_0000, 32'h00C0_FFEE, 32'h0, 32'h0, 32'h0};
        load(16'hFFFE, 1'b0);
        expect_ev(KNode, 32'h00C0_FFEE);
        expect_ev(KChg, 32'h0);
        expect_ev(KDone, 32'h0);
        r0 = req_cnt;
        go(16'hFFFE);
        wait_done("wrap");
        finish_check("wrap", r0, 6 + CS, 1'b0);
        check("wrap_final_addr", 32'(mem_addr), 32'h0004 + 32'(CS));

        // Abort during NODE, then a clean reload with a start ignored mid-load.
        lat_max = 3;
        set_img_a();
        load(16'h0400, 1'b0);
        expect_a();
        r0 = req_cnt;
        go(16'h0400);
        n = 0;
        while (req_cnt < r0 + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_node", {31'd0, req_cnt >= r0 + 4}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {mem_req, mem_addr, node_out, node_valid, ptr_out, ptr_valid, change_eng,
               uc_lit, uc_valid, uc_done, busy, done, err} == '0 ? 32'd0 : 32'd1, 32'd0);
        exp_kind.delete();
        exp_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r1 = req_cnt;
        repeat (10) @(negedge clk);
        check("abort_idle", {30'd0, busy, done}, 32'b00);
        check("abort_no_req", 32'(req_cnt - r1), 32'd0);
        expect_a();
        r0 = req_cnt;
        go(16'h0400);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 16'h0200;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("reload");
        finish_check("reload", r0, 10 + CS, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum flags err, next accepted start clears it.
        lat_max = 1;
        set_img_a();
        load(16'h0500, 1'b1);
        expect_a();
        r0 = req_cnt;
        go(16'h0500);
        wait_done("bad_csum");
        finish_check("bad_csum", r0, 11, 1'b1);
        expect_a();
        r0 = req_cnt;
        go(16'h0100);
        wait_done("good_csum");
        finish_check("good_csum", r0, 11, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
